// File: rtl/input_fetch_streamer_pkg.sv
// Shared constants and FSM encoding for the input-SRAM fetch streamer.
package input_fetch_streamer_pkg;

  localparam int INPUT_SRAM_WORDS = 12288;
  localparam int INPUT_ROW_WORDS  = 2048;
  localparam int INPUT_DATA_W     = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/input_stream_fifo.sv
// Output skid FIFO; registered read side, so a push is visible one cycle later.
module input_stream_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 129
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/input_fetch_streamer.sv
// Streams a range of input-SRAM words out through a skid FIFO, one read outstanding at a time.
module input_fetch_streamer
  import input_fetch_streamer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 14
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       r_addr,
  output logic              r_en,
  input  logic [127:0]      r_d,
  input  logic              d_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      out_data,
  output logic              out_last
);

  state_t                     state_q, state_d;
  logic [31:0]                addr_q;
  logic [CNT_W-1:0]           remaining_q;
  logic                       done_q, err_q;
  logic [32:0]                end_addr;
  logic                       range_bad;
  logic                       fifo_push, fifo_pop, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [INPUT_DATA_W:0]      fifo_rdata;

  assign end_addr  = {1'b0, base_addr} + {{(33-CNT_W){1'b0}}, word_count};
  assign range_bad = end_addr > 33'(INPUT_SRAM_WORDS);

  assign fifo_push = (state_q == WAIT) && d_ready;
  assign fifo_pop  = !fifo_empty && out_ready;

  input_stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (INPUT_DATA_W + 1)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({remaining_q == CNT_W'(1), r_d}),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    r_en    = 1'b0;
    case (state_q)
      IDLE:
        if (start && !range_bad && word_count != '0) state_d = ISSUE;
      ISSUE:
        // Only issue when the word has a guaranteed FIFO slot to land in.
        if (int'(fifo_count) < FIFO_DEPTH) begin
          r_en    = 1'b1;
          state_d = WAIT;
        end
      WAIT:
        if (d_ready) state_d = (remaining_q == CNT_W'(1)) ? DRAIN : ISSUE;
      DRAIN:
        if (fifo_empty) state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE:
          if (start) begin
            if (range_bad) begin
              err_q <= 1'b1;
            end else if (word_count == '0) begin
              done_q <= 1'b1;
            end else begin
              addr_q      <= base_addr;
              remaining_q <= word_count;
            end
          end
        WAIT:
          if (d_ready) begin
            addr_q      <= addr_q + 32'd1;
            remaining_q <= remaining_q - 1'b1;
          end
        DRAIN:
          if (fifo_empty) done_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign r_addr    = addr_q;
  assign out_valid = !fifo_empty;
  assign out_data  = fifo_rdata[INPUT_DATA_W-1:0];
  assign out_last  = !fifo_empty && fifo_rdata[INPUT_DATA_W];

endmodule

// File: tb/tb_input_fetch_streamer.sv
// Directed bench for input_fetch_streamer with a 2-cycle-latency SRAM controller model.
module tb_input_fetch_streamer;

  logic         clock;
  logic         reset;
  logic         start;
  logic [31:0]  base_addr;
  logic [13:0]  word_count;
  logic         busy, done, err;
  logic [31:0]  r_addr;
  logic         r_en;
  logic [127:0] r_d;
  logic         d_ready;
  logic         out_valid, out_ready, out_last;
  logic [127:0] out_data;

  int checks = 0;
  int errors = 0;

  logic [31:0]  rd_q[$];
  logic [128:0] beat_q[$];
  int           done_n = 0;
  int           err_n  = 0;

  input_fetch_streamer #(
    .FIFO_DEPTH (4),
    .CNT_W      (14)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .r_addr     (r_addr),
    .r_en       (r_en),
    .r_d        (r_d),
    .d_ready    (d_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [127:0] word(input logic [31:0] a);
    return {32'hDEAD_BEEF, a, ~a, a ^ 32'h5A5A_0000};
  endfunction

  // Controller model: data returns two cycles after the r_en cycle; not cleared by reset.
  logic        p1_v = 1'b0;
  logic [31:0] p1_a = '0;
  initial d_ready = 1'b0;
  always @(posedge clock) begin
    p1_v    <= r_en;
    p1_a    <= r_addr;
    d_ready <= p1_v;
    r_d     <= word(p1_a);
  end

  always @(negedge clock) begin
    if (!reset) begin
      if (r_en) rd_q.push_back(r_addr);
      if (out_valid && out_ready) beat_q.push_back({out_last, out_data});
      if (done) done_n++;
      if (err) err_n++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    rd_q.delete();
    beat_q.delete();
    done_n = 0;
    err_n  = 0;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [31:0] b, input logic [13:0] n);
    base_addr  = b;
    word_count = n;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cycles);
    bit seen = 0;
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
    end
    chk(tag, 128'(seen), 128'd1);
  endtask

  task automatic check_burst(input string tag, input logic [31:0] b, input int n);
    logic [128:0] bt;
    chk({tag, "_reads"}, 128'(rd_q.size()), 128'(n));
    chk({tag, "_beats"}, 128'(beat_q.size()), 128'(n));
    for (int i = 0; i < n; i++) begin
      if (i < rd_q.size()) chk({tag, "_raddr"}, 128'(rd_q[i]), 128'(b + 32'(i)));
      if (i < beat_q.size()) begin
        bt = beat_q[i];
        chk({tag, "_data"}, bt[127:0], word(b + 32'(i)));
        chk({tag, "_last"}, 128'(bt[128]), 128'(i == n - 1));
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    out_ready  = 1'b1;
    repeat (3) tick();

    chk("rst_busy",  128'(busy),      128'd0);
    chk("rst_done",  128'(done),      128'd0);
    chk("rst_err",   128'(err),       128'd0);
    chk("rst_ren",   128'(r_en),      128'd0);
    chk("rst_valid", 128'(out_valid), 128'd0);
    chk("rst_last",  128'(out_last),  128'd0);
    chk("rst_raddr", 128'(r_addr),    128'd0);
    reset = 1'b0;
    tick();
    clr();

    // Basic 4-word burst
    pulse_start(32'd0, 14'd4);
    chk("b0_busy", 128'(busy), 128'd1);
    chk("b0_ren",  128'(r_en), 128'd1);
    wait_done("b0_done_seen", 100);
    chk("b0_busy_after", 128'(busy), 128'd0);
    tick();
    tick();
    chk("b0_done_once", 128'(done_n), 128'd1);
    check_burst("b0", 32'd0, 4);

    // Range overflow by one word
    clr();
    pulse_start(32'd12286, 14'd3);
    chk("rng_err",  128'(err),  128'd1);
    chk("rng_busy", 128'(busy), 128'd0);
    tick();
    chk("rng_err_pulse", 128'(err), 128'd0);
    repeat (6) tick();
    chk("rng_busy_later", 128'(busy),        128'd0);
    chk("rng_no_reads",   128'(rd_q.size()), 128'd0);
    chk("rng_err_once",   128'(err_n),       128'd1);

    // Exactly fills the SRAM: accepted
    clr();
    pulse_start(32'd12285, 14'd3);
    chk("edge_err",  128'(err),  128'd0);
    chk("edge_busy", 128'(busy), 128'd1);
    wait_done("edge_done_seen", 100);
    tick();
    check_burst("edge", 32'd12285, 3);

    // Zero-length burst
    clr();
    pulse_start(32'd50, 14'd0);
    chk("zero_done", 128'(done), 128'd1);
    chk("zero_busy", 128'(busy), 128'd0);
    tick();
    chk("zero_done_pulse", 128'(done), 128'd0);
    repeat (4) tick();
    chk("zero_reads", 128'(rd_q.size()),   128'd0);
    chk("zero_beats", 128'(beat_q.size()), 128'd0);

    // Backpressure across a row boundary
    clr();
    out_ready = 1'b0;
    pulse_start(32'd2046, 14'd4);
    repeat (20) tick();
    chk("bp_reads", 128'(rd_q.size()),   128'd4);
    chk("bp_beats", 128'(beat_q.size()), 128'd0);
    chk("bp_valid", 128'(out_valid),     128'd1);
    chk("bp_head",  out_data,            word(32'd2046));
    chk("bp_last",  128'(out_last),      128'd0);
    chk("bp_busy",  128'(busy),          128'd1);
    chk("bp_ren",   128'(r_en),          128'd0);
    tick();
    chk("bp_head_stable", out_data, word(32'd2046));
    out_ready = 1'b1;
    wait_done("bp_done_seen", 50);
    tick();
    check_burst("bp", 32'd2046, 4);

    // Start while busy is ignored
    clr();
    pulse_start(32'd100, 14'd3);
    tick();
    pulse_start(32'd500, 14'd7);
    wait_done("ign_done_seen", 100);
    repeat (8) tick();
    chk("ign_done_once", 128'(done_n), 128'd1);
    check_burst("ign", 32'd100, 3);

    // Reset while waiting for the second word
    clr();
    pulse_start(32'd200, 14'd3);
    begin
      bit found = 0;
      for (int i = 0; i < 50; i++) begin
        if (r_en === 1'b1 && r_addr === 32'd201) begin
          found = 1;
          break;
        end
        tick();
      end
      chk("rst2_second_read", 128'(found), 128'd1);
    end
    tick();
    reset = 1'b1;
    tick();
    chk("rst2_busy",  128'(busy),      128'd0);
    chk("rst2_ren",   128'(r_en),      128'd0);
    chk("rst2_valid", 128'(out_valid), 128'd0);
    chk("rst2_last",  128'(out_last),  128'd0);
    chk("rst2_done",  128'(done),      128'd0);
    chk("rst2_raddr", 128'(r_addr),    128'd0);
    reset = 1'b0;
    clr();
    repeat (6) tick();
    chk("rst2_no_beats", 128'(beat_q.size()), 128'd0);
    chk("rst2_valid_later", 128'(out_valid), 128'd0);
    chk("rst2_idle", 128'(busy), 128'd0);

    clr();
    pulse_start(32'd300, 14'd2);
    wait_done("post_done_seen", 100);
    tick();
    check_burst("post", 32'd300, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/input_fetch_streamer.md
INPUT_FETCH_STREAMER -- requirements
Module: input_fetch_streamer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, output skid-FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter CNT_W, default 14, width of word-count input.
REQ-003 SHALL have: clock  input  1  sole clock, all logic on posedge.
REQ-004 SHALL have: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have: start  input  1  one-cycle request to begin a fetch burst.
REQ-006 SHALL have: base_addr  input  32  first SRAM word address, sampled on accepted start.
REQ-007 SHALL have: word_count  input  CNT_W  words to fetch, sampled on accepted start.
REQ-008 SHALL have: busy  output  1  burst in progress.
REQ-009 SHALL have: done  output  1  one-cycle pulse at burst completion.
REQ-010 SHALL have: err  output  1  one-cycle pulse when a start is rejected for range.
REQ-011 SHALL have: r_addr  output  32  read address to input SRAM controller.
REQ-012 SHALL have: r_en  output  1  read request to input SRAM controller.
REQ-013 SHALL have: r_d  input  128  read data from controller.
REQ-014 SHALL have: d_ready  input  1  controller read-data-valid pulse.
REQ-015 SHALL have: out_valid  output  1; out_ready  input  1; out_data  output  128; out_last  output  1 (marks final word of burst).

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT, DRAIN.
REQ-017 IDLE: start accepted only in IDLE; start while busy SHALL be ignored.
REQ-018 Range check on start: base_addr + word_count > 12288 (6 rows x 2048) SHALL pulse err next cycle, stay IDLE, issue no reads.
REQ-019 word_count == 0 SHALL pulse done next cycle with no reads and no output beats.
REQ-020 Valid start SHALL load addr=base_addr, remaining=word_count, go to ISSUE next cycle; busy=1 from that cycle until done.
REQ-021 ISSUE: if fifo_count + 1 <= FIFO_DEPTH (no outstanding read), assert r_en for exactly one cycle, go WAIT; else stall in ISSUE with r_en=0.
REQ-022 r_addr SHALL hold the current address stable from ISSUE through the d_ready cycle.
REQ-023 At most one read outstanding; r_en SHALL never be asserted in WAIT.
REQ-024 WAIT: on d_ready, write r_d into FIFO same edge, increment addr, decrement remaining; remaining becomes 0 -> DRAIN, else -> ISSUE.
REQ-025 Expected controller latency: d_ready two cycles after r_en cycle; block SHALL tolerate any latency >=1.
REQ-026 d_ready outside WAIT SHALL be ignored (no FIFO write).
REQ-027 out_last SHALL accompany the beat holding the final word; tagged in FIFO (129-bit entries).
REQ-028 Output beat transfers when out_valid && out_ready; out_data/out_last SHALL stay stable while out_valid && !out_ready.
REQ-029 FIFO simultaneous push and pop when full SHALL not occur (REQ-021 reservation); when empty, push-then-pop earliest next cycle (no bypass).
REQ-030 DRAIN: when FIFO empty after last beat popped, pulse done, busy=0, return IDLE.
REQ-031 Peak throughput: one word per 3 cycles with 2-cycle controller latency.

Reset
REQ-032 Reset SHALL force IDLE, FIFO empty, and busy, done, err, r_en, out_valid, out_last = 0, r_addr = 0.
REQ-033 Reset mid-burst SHALL abandon the burst; a d_ready arriving after reset SHALL be ignored.

Structure
REQ-034 Shared package SHALL hold INPUT_SRAM_WORDS=12288, INPUT_ROW_WORDS=2048, INPUT_DATA_W=128, FSM state enum.
REQ-035 FIFO SHALL be sub-module input_stream_fifo (parameterised depth/width, count output).

Verification
REQ-036 start base=0, count=4, out_ready=1, controller model latency 2 -> r_en at addrs 0,1,2,3; 4 beats in order, out_last on 4th; done pulse once.
REQ-037 start base=12286, count=3 -> err pulse, r_en never asserted, busy stays 0.
REQ-038 start count=0 -> done next cycle, zero beats.
REQ-039 base=2046, count=4, out_ready=0 for 20 cycles -> exactly 4 reads, FIFO holds words 2046..2049 (row crossing), no 5th read; release -> 4 beats then done.
REQ-040 reset asserted in WAIT of 2nd word, d_ready arrives after -> all outputs 0, no beat emitted; new start works normally.
REQ-041 start pulsed while busy -> ignored; burst unaffected.
